// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one combinational-read memory between an
// instruction-fetch port and a data load/store port. One transaction is in
// flight at a time. Data normally has priority. After MAX_DATA_STREAK
// consecutive contested data grants, a waiting fetch is forced through.

module mem_port_arbiter #(
    parameter int LATENCY         = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst_b,

    input  logic            i_req,
    input  logic [31:0]     i_addr,
    output logic [0:3][7:0] i_rdata,
    output logic            i_ready,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [31:0]     d_addr,
    input  logic [0:3][7:0] d_wdata,
    output logic [0:3][7:0] d_rdata,
    output logic            d_ready,

    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_data_in,
    output logic            mem_we,
    input  logic [0:3][7:0] mem_data_out,

    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    // The access counter runs 0..LATENCY-1, so the final access cycle is
    // the one where it reads LATENCY-1.
    localparam logic [3:0] LAST_CYCLE = 4'(LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t          state;
    state_t          state_next;

    owner_t          owner;
    logic [31:0]     addr;
    logic            we;
    logic [0:3][7:0] wdata;

    logic [3:0]      cycle_count;
    logic [3:0]      streak;

    logic            fetch_forced;
    logic            grant_data;
    logic            start;
    logic            last_access;

    // Arbitration and handy strobes. The fetch is forced only while both
    // sides are asking and data has already won STREAK_MAX times in a row.
    always_comb begin
        fetch_forced = i_req && d_req && (streak == STREAK_MAX);
        grant_data   = d_req && !fetch_forced;
        start        = (state == IDLE) && (i_req || d_req);
        last_access  = (state == ACCESS) && (cycle_count == LAST_CYCLE);
    end

    // State register; reset returns to IDLE and abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave IDLE on any request, stay in ACCESS for
    // LATENCY cycles, then spend one cycle in RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cycle_count == LAST_CYCLE) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winning request on the IDLE->ACCESS edge so requesters
    // can change or drop their inputs while the access runs.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            owner <= OWNER_FETCH;
            addr  <= '0;
            we    <= 1'b0;
            wdata <= '0;
        end else if (start) begin
            if (grant_data) begin
                owner <= OWNER_DATA;
                addr  <= d_addr;
                we    <= d_we;
                wdata <= d_wdata;
            end else begin
                owner <= OWNER_FETCH;
                addr  <= i_addr;
                we    <= 1'b0;
                wdata <= '0;
            end
        end
    end

    // Count access cycles. The counter sits at zero outside ACCESS so every
    // transaction starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cycle_count <= '0;
        end else if ((state == ACCESS) && (cycle_count != LAST_CYCLE)) begin
            cycle_count <= cycle_count + 4'd1;
        end else begin
            cycle_count <= '0;
        end
    end

    // Starvation guard. The streak counts data grants made while a fetch was
    // also waiting. Any fetch grant, or a data grant with no fetch waiting,
    // resets it.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            streak <= '0;
        end else if (start) begin
            if (grant_data && i_req) begin
                streak <= (streak >= STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
            end else begin
                streak <= '0;
            end
        end
    end

    // Read data is taken from memory on the last access cycle. Only the
    // owner's register is loaded; the other port keeps its last word.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (last_access) begin
            if (owner == OWNER_FETCH) begin
                i_rdata <= mem_data_out;
            end else if (!we) begin
                d_rdata <= mem_data_out;
            end
        end
    end

    // Outputs decoded from state. The memory bus is driven only during
    // ACCESS. A store writes only in its last access cycle. The ready of
    // the latched owner pulses in RESP.
    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_we      = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        busy        = 1'b0;
        case (state)
            ACCESS: begin
                busy     = 1'b1;
                mem_addr = addr;
                if ((owner == OWNER_DATA) && we) begin
                    mem_data_in = wdata;
                    mem_we      = (cycle_count == LAST_CYCLE);
                end
            end
            RESP: begin
                busy    = 1'b1;
                i_ready = (owner == OWNER_FETCH);
                d_ready = (owner == OWNER_DATA);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, meaning memory access cycles per transaction; legal range 1..15.
REQ-002 Parameter MAX_DATA_STREAK, default 4, meaning consecutive contested data grants before a pending fetch is forced through; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, synchronous and active-low.
REQ-005 i_req  input  1  instruction-fetch request; held until i_ready.
REQ-006 i_addr  input  32  fetch byte address.
REQ-007 i_rdata  output  4x8  fetched word; byte [0] most significant.
REQ-008 i_ready  output  1  one-cycle pulse; i_rdata valid in that cycle.
REQ-009 d_req  input  1  data request; held until d_ready.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  4x8  store word.
REQ-013 d_rdata  output  4x8  load word.
REQ-014 d_ready  output  1  one-cycle completion pulse for load or store.
REQ-015 mem_addr  output  32  address to shared memory.
REQ-016 mem_data_in  output  4x8  write data to shared memory.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_data_out  input  4x8  memory read data, combinational from mem_addr.
REQ-019 busy  output  1  high in ACCESS and RESP states.

Function
REQ-020 FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS when i_req or d_req is 1; ACCESS->RESP after exactly LATENCY cycles; RESP->IDLE unconditionally.
REQ-021 On IDLE->ACCESS the block SHALL latch owner, addr, we, wdata; input changes during ACCESS/RESP SHALL be ignored.
REQ-022 Arbitration: data wins over fetch, except when both request and streak == MAX_DATA_STREAK, in which case fetch wins.
REQ-023 Streak counter (4 bits) SHALL increment, saturating at MAX_DATA_STREAK, on a data grant with i_req=1; SHALL clear on any fetch grant or on a data grant with i_req=0.
REQ-024 During ACCESS, mem_addr SHALL equal latched address; in IDLE and RESP mem_addr SHALL be 0.
REQ-025 mem_we SHALL be 1 only in the final ACCESS cycle of a data store, exactly one cycle per store; fetches never write.
REQ-026 mem_data_in SHALL equal latched wdata during a store ACCESS, else 0.
REQ-027 In the final ACCESS cycle of a load or fetch, mem_data_out SHALL be captured into d_rdata or i_rdata respectively; the other rdata register SHALL hold its value.
REQ-028 In RESP, ready of the latched owner SHALL be 1 for exactly one cycle; the other ready SHALL be 0.
REQ-029 Latency: request sampled in IDLE at cycle t -> ready at cycle t+LATENCY+1; minimum turnaround back to IDLE is LATENCY+2 cycles per transaction.
REQ-030 A requester dropping req mid-transaction SHALL NOT abort it; the store still writes and ready still pulses.
REQ-031 A req still high in the cycle after its ready pulse SHALL be treated as a new request in IDLE.
REQ-032 At most one transaction SHALL be outstanding; no request SHALL be granted while busy=1.

Reset
REQ-033 With rst_b=0 at a rising edge: state IDLE, streak 0, i_rdata and d_rdata 0, all outputs 0 in the following cycle.
REQ-034 Reset asserted mid-ACCESS SHALL abort the transaction: no mem_we pulse, no ready pulse, latched request discarded.

Verification
REQ-035 Fetch only: i_req=1, i_addr=0x40, mem word 0x20080005 -> i_ready pulse 3 cycles later, i_rdata=0x20080005, mem_we never 1.
REQ-036 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1 exactly one cycle with mem_addr=0x100; d_ready one cycle later; readback load returns 0xDEADBEEF.
REQ-037 Contention: i_req and d_req held continuously with d_req re-raised after each d_ready -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-038 Simultaneous first request, both asserted in same IDLE cycle, streak 0 -> data granted first, fetch granted next; i_ready never coincides with d_ready.
REQ-039 Reset mid-store: rst_b=0 in first ACCESS cycle of store to 0x200 -> no mem_we, no d_ready, memory at 0x200 unchanged, busy=0 after reset.
REQ-040 Request drop: d_req pulsed 1 cycle for load of 0x80 -> transaction completes, d_ready pulses once, d_rdata = mem[0x80].
